// File: rtl/pixel_ctrl_pkg.sv
// Shared constants and types for the pixel grid renderer.
// Default geometry: 32x24 cells of 32x32 pixels on a 1024x768 XGA raster.
package pixel_ctrl_pkg;

    localparam int COLOR_W    = 12;
    localparam int CELL_SHIFT = 5;
    localparam int GRID_W     = 32;
    localparam int GRID_H     = 24;
    localparam int GRID_CELLS = GRID_W * GRID_H;

    localparam logic [11:0] COLOR_BLACK  = 12'h000;
    localparam logic [11:0] COLOR_CURSOR = 12'hFFF;
    localparam logic [11:0] COLOR_GRID   = 12'h444;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/grid_ram.sv
// Simple dual-port cell colour RAM: one write port, one synchronous read port.
// A read and a write to the same address in one cycle return the old data.
module grid_ram #(
    parameter int DEPTH  = 768,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array write; contents are initialised by the owner's clear sweep.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read; non-blocking update of mem makes a collision read-first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_grid_renderer.sv
// Pixel source for the XGA output path: a grid of single-colour cells held in
// on-chip RAM, a button-driven cursor, and a paint strobe writing the cursor
// cell. Pixel and sync/blank outputs lag hcount/vcount by exactly 2 cycles.
// Optional build macro GRID_LINES_EN draws 12'h444 lines on cell top/left edges.
module pixel_grid_renderer #(
    parameter int CELL_SHIFT = pixel_ctrl_pkg::CELL_SHIFT,
    parameter int GRID_W     = pixel_ctrl_pkg::GRID_W,
    parameter int GRID_H     = pixel_ctrl_pkg::GRID_H,
    parameter int COLOR_W    = pixel_ctrl_pkg::COLOR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [10:0]        hcount,
    input  logic [10:0]        vcount,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               blank,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               paint,
    input  logic [COLOR_W-1:0] paint_color,
    output logic [COLOR_W-1:0] pixel,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out,
    output logic [4:0]         cursor_x,
    output logic [4:0]         cursor_y,
    output logic               ready
);

    import pixel_ctrl_pkg::*;

    localparam int CELLS  = GRID_W * GRID_H;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CUR_W  = 5;
    localparam int CX_W   = 11 - CELL_SHIFT;

    localparam logic [CX_W-1:0]       GRID_W_C  = CX_W'(GRID_W);
    localparam logic [CX_W-1:0]       GRID_H_C  = CX_W'(GRID_H);
    localparam logic [CUR_W-1:0]      X_MAX     = CUR_W'(GRID_W - 1);
    localparam logic [CUR_W-1:0]      Y_MAX     = CUR_W'(GRID_H - 1);
    localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [CELL_SHIFT-1:0] LOW_ONES  = '1;

    localparam logic [COLOR_W-1:0] PIX_BLACK  = COLOR_W'(COLOR_BLACK);
    localparam logic [COLOR_W-1:0] PIX_CURSOR = COLOR_W'(COLOR_CURSOR);
`ifdef GRID_LINES_EN
    localparam logic [COLOR_W-1:0] PIX_GRID   = COLOR_W'(COLOR_GRID);
`endif

    // Linear RAM index of a cell: row-major, GRID_W cells per row.
    function automatic logic [ADDR_W-1:0] cell_index(input logic [ADDR_W-1:0] y,
                                                     input logic [ADDR_W-1:0] x);
        return y * ADDR_W'(GRID_W) + x;
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic               ready_q, ready_d;
    logic [CUR_W-1:0]   cursor_x_q, cursor_x_d;
    logic [CUR_W-1:0]   cursor_y_q, cursor_y_d;
    logic [4:0]         btn_hist_q;
    logic [4:0]         btn_now;
    logic [4:0]         btn_rise;

    // Button vector layout: {paint, up, down, left, right}.
    assign btn_now  = {paint, up, down, left, right};
    assign btn_rise = btn_now & ~btn_hist_q;

    logic rise_right, rise_left, rise_down, rise_up, rise_paint;
    assign rise_right = btn_rise[0];
    assign rise_left  = btn_rise[1];
    assign rise_down  = btn_rise[2];
    assign rise_up    = btn_rise[3];
    assign rise_paint = btn_rise[4];

    // FSM state, clear-sweep address and ready flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    // FSM next state: sweep every cell to zero once, then run forever.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ready_d    = ready_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                    ready_d    = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d    = CLEAR;
                clr_addr_d = '0;
                ready_d    = 1'b0;
            end
        endcase
    end

    // Button edge history and cursor position registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_hist_q <= '0;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
        end else begin
            btn_hist_q <= btn_now;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
        end
    end

    // Cursor moves on rising edges with wrap; opposing edges on one axis cancel.
    always_comb begin
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        if (state_q == RUN) begin
            if (rise_right && !rise_left) begin
                cursor_x_d = (cursor_x_q == X_MAX) ? '0 : cursor_x_q + 1'b1;
            end else if (rise_left && !rise_right) begin
                cursor_x_d = (cursor_x_q == '0) ? X_MAX : cursor_x_q - 1'b1;
            end
            if (rise_down && !rise_up) begin
                cursor_y_d = (cursor_y_q == Y_MAX) ? '0 : cursor_y_q + 1'b1;
            end else if (rise_up && !rise_down) begin
                cursor_y_d = (cursor_y_q == '0) ? Y_MAX : cursor_y_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM write port: clear sweep during CLEAR, paint at the pre-move cursor in RUN
    // ------------------------------------------------------------------
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;

    // Write-port mux between the clear sweep and the paint strobe.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
        end else if (rise_paint) begin
            wr_en   = 1'b1;
            wr_addr = cell_index(ADDR_W'(cursor_y_q), ADDR_W'(cursor_x_q));
            wr_data = paint_color;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0 -> 1: cell decode of the incoming raster position
    // ------------------------------------------------------------------
    logic [CX_W-1:0]       cell_x_p0, cell_y_p0;
    logic                  in_grid_p0;
    logic [ADDR_W-1:0]     rd_addr_p0;

    assign cell_x_p0  = hcount[10:CELL_SHIFT];
    assign cell_y_p0  = vcount[10:CELL_SHIFT];
    assign in_grid_p0 = (cell_x_p0 < GRID_W_C) && (cell_y_p0 < GRID_H_C);
    // Off-grid positions read cell 0 so the RAM index never leaves range.
    assign rd_addr_p0 = in_grid_p0 ? cell_index(ADDR_W'(cell_y_p0), ADDR_W'(cell_x_p0))
                                   : '0;

    logic [CX_W-1:0]       cell_x_p1_q, cell_y_p1_q;
    logic [CELL_SHIFT-1:0] hlow_p1_q, vlow_p1_q;
    logic                  in_grid_p1_q;
    logic                  hsync_p1_q, vsync_p1_q, blank_p1_q;

    // Stage 1 register: cell coordinates, in-cell offsets, grid flag, syncs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cell_x_p1_q  <= '0;
            cell_y_p1_q  <= '0;
            hlow_p1_q    <= '0;
            vlow_p1_q    <= '0;
            in_grid_p1_q <= 1'b0;
            hsync_p1_q   <= 1'b0;
            vsync_p1_q   <= 1'b0;
            blank_p1_q   <= 1'b0;
        end else begin
            cell_x_p1_q  <= cell_x_p0;
            cell_y_p1_q  <= cell_y_p0;
            hlow_p1_q    <= hcount[CELL_SHIFT-1:0];
            vlow_p1_q    <= vcount[CELL_SHIFT-1:0];
            in_grid_p1_q <= in_grid_p0;
            hsync_p1_q   <= hsync;
            vsync_p1_q   <= vsync;
            blank_p1_q   <= blank;
        end
    end

    // The RAM's own read register lines its output up with the stage 1 registers.
    logic [COLOR_W-1:0] ram_color_p1;

    grid_ram #(
        .DEPTH  (CELLS),
        .DATA_W (COLOR_W),
        .ADDR_W (ADDR_W)
    ) u_grid_ram (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_addr_p0),
        .rdata_o (ram_color_p1)
    );

    // ------------------------------------------------------------------
    // Stage 1 -> 2: overlay mux and output register
    // ------------------------------------------------------------------
    logic               in_cursor_cell_p1;
    logic               on_edge_p1;
    logic [COLOR_W-1:0] pixel_d;

    assign in_cursor_cell_p1 = in_grid_p1_q
                             && (cell_x_p1_q == CX_W'(cursor_x_q))
                             && (cell_y_p1_q == CX_W'(cursor_y_q));
    assign on_edge_p1 = (hlow_p1_q == '0) || (hlow_p1_q == LOW_ONES)
                     || (vlow_p1_q == '0) || (vlow_p1_q == LOW_ONES);

    // Priority select: blank, off-grid, cursor border, grid line, cell colour.
    always_comb begin
        pixel_d = PIX_BLACK;
        if (state_q != RUN) begin
            pixel_d = PIX_BLACK;
        end else if (blank_p1_q) begin
            pixel_d = PIX_BLACK;
        end else if (!in_grid_p1_q) begin
            pixel_d = PIX_BLACK;
        end else if (in_cursor_cell_p1 && on_edge_p1) begin
            pixel_d = PIX_CURSOR;
`ifdef GRID_LINES_EN
        end else if ((hlow_p1_q == '0) || (vlow_p1_q == '0)) begin
            pixel_d = PIX_GRID;
`endif
        end else begin
            pixel_d = ram_color_p1;
        end
    end

    logic [COLOR_W-1:0] pixel_p2_q;
    logic               hsync_p2_q, vsync_p2_q, blank_p2_q;

    // Stage 2 register: pixel and the matching second sync/blank delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_p2_q <= '0;
            hsync_p2_q <= 1'b0;
            vsync_p2_q <= 1'b0;
            blank_p2_q <= 1'b0;
        end else begin
            pixel_p2_q <= pixel_d;
            hsync_p2_q <= hsync_p1_q;
            vsync_p2_q <= vsync_p1_q;
            blank_p2_q <= blank_p1_q;
        end
    end

    assign pixel     = pixel_p2_q;
    assign hsync_out = hsync_p2_q;
    assign vsync_out = vsync_p2_q;
    assign blank_out = blank_p2_q;
    assign cursor_x  = cursor_x_q;
    assign cursor_y  = cursor_y_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_pixel_grid_renderer.sv
// Directed scoreboard bench for pixel_grid_renderer (default 32x24 grid).
module tb_pixel_grid_renderer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [10:0] hcount, vcount;
    logic        hsync, vsync, blank;
    logic        up, down, left, right, paint;
    logic [11:0] paint_color;
    logic [11:0] pixel;
    logic        hsync_out, vsync_out, blank_out;
    logic [4:0]  cursor_x, cursor_y;
    logic        ready;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pix    = 0;

    typedef struct packed {
        logic [11:0] pix;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    exp_t       exp_q[$];
    logic [11:0] mem_m [768];
    int         ex_cx = 0;
    int         ex_cy = 0;
    bit         drive_vld = 1'b0;
    bit [1:0]   vld_sh = 2'b00;

    pixel_grid_renderer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .paint       (paint),
        .paint_color (paint_color),
        .pixel       (pixel),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_out   (blank_out),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .ready       (ready)
    );

    always #5 clock = ~clock;

    // Reference pixel for a raster position given the bench's cursor and cell colours.
    function automatic logic [11:0] model_pix(input int h, input int v, input bit blk);
        int cx, cy, hl, vl;
        cx = h >> 5;
        cy = v >> 5;
        hl = h & 31;
        vl = v & 31;
        if (blk) return 12'h000;
        if (cx >= 32 || cy >= 24) return 12'h000;
        if (cx == ex_cx && cy == ex_cy && (hl == 0 || hl == 31 || vl == 0 || vl == 31))
            return 12'hFFF;
`ifdef GRID_LINES_EN
        if (hl == 0 || vl == 0) return 12'h444;
`endif
        return mem_m[cy * 32 + cx];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 768; i++) mem_m[i] = 12'h000;
    endtask

    task automatic drive(input int h, input int v, input bit blk, input bit hs, input bit vs);
        exp_t e;
        hcount = 11'(h);
        vcount = 11'(v);
        blank  = blk;
        hsync  = hs;
        vsync  = vs;
        e.pix  = model_pix(h, v, blk);
        e.hs   = hs;
        e.vs   = vs;
        e.bl   = blk;
        exp_q.push_back(e);
        drive_vld = 1'b1;
        tick();
    endtask

    task automatic flush();
        drive_vld = 1'b0;
        hcount = '0; vcount = '0; blank = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (3) tick();
    endtask

    // Button index: 0 right, 1 left, 2 down, 3 up, 4 paint.
    task automatic set_btn(input int b, input logic val);
        case (b)
            0: right = val;
            1: left  = val;
            2: down  = val;
            3: up    = val;
            default: paint = val;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        tick();
        set_btn(b, 1'b0);
        tick();
    endtask

    task automatic move_model(input int dx, input int dy);
        ex_cx = (ex_cx + dx + 32) % 32;
        ex_cy = (ex_cy + dy + 24) % 24;
    endtask

    task automatic check_cursor(input string tag);
        n_assert++;
        assert ({cursor_x, cursor_y} === {5'(ex_cx), 5'(ex_cy)}) else begin
            n_fail++;
            $error("FAIL %s cursor observed=(%0d,%0d) expected=(%0d,%0d)",
                   tag, cursor_x, cursor_y, ex_cx, ex_cy);
        end
    endtask

    task automatic count_ready(input string tag);
        int cnt;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ready && cnt < 2000);
        n_assert++;
        assert (cnt == 768) else begin
            n_fail++;
            $error("FAIL %s ready_latency observed=%0d expected=768", tag, cnt);
        end
    endtask

    // Scoreboard pipeline: an expectation matures two clocks after it is driven.
    always @(posedge clock) vld_sh <= {vld_sh[0], drive_vld};

    // Pop and compare each matured expectation away from the active edge.
    always @(negedge clock) begin
        if (vld_sh[1]) begin
            exp_t e;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL scoreboard_underflow observed=empty expected=entry");
            end else begin
                e = exp_q.pop_front();
                assert (pixel === e.pix) else begin
                    n_fail++;
                    $error("FAIL pix#%0d observed=%h expected=%h", n_pix, pixel, e.pix);
                end
                n_assert++;
                assert ({hsync_out, vsync_out, blank_out} === {e.hs, e.vs, e.bl}) else begin
                    n_fail++;
                    $error("FAIL sync#%0d observed=%b expected=%b", n_pix,
                           {hsync_out, vsync_out, blank_out}, {e.hs, e.vs, e.bl});
                end
                n_pix++;
            end
        end
    end

    initial begin
        int lines [6];
        lines = '{0, 31, 32, 400, 767, 771};
        reset_n = 1'b1;
        hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0; blank = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; paint = 1'b0;
        paint_color = '0;
        clear_model();
        #2 reset_n = 1'b0;
        repeat (3) tick();

        // Reset state
        n_assert++;
        assert ({pixel, hsync_out, vsync_out, blank_out, cursor_x, cursor_y, ready} === '0) else begin
            n_fail++;
            $error("FAIL reset_state observed=%h/%b%b%b/%0d,%0d/%b expected=all zero",
                   pixel, hsync_out, vsync_out, blank_out, cursor_x, cursor_y, ready);
        end

        reset_n = 1'b1;
        count_ready("first_clear");

        // Frame lines: only the cursor border of cell (0,0) is lit
        foreach (lines[k]) begin
            for (int h = 0; h < 1344; h++) begin
                drive(h, lines[k], (h >= 1024) || (lines[k] >= 768),
                      (h == 1048), (lines[k] == 771));
            end
        end
        flush();

        // Move to (3,2) and paint red
        repeat (3) begin press(0); move_model(1, 0); end
        repeat (2) begin press(2); move_model(0, 1); end
        check_cursor("move_3_2");
        paint_color = 12'hF00;
        press(4);
        mem_m[2 * 32 + 3] = 12'hF00;

        drive(100, 80, 1'b0, 1'b0, 1'b0);
        drive(96, 80, 1'b0, 1'b0, 1'b0);
        drive(1030, 80, 1'b0, 1'b0, 1'b0);
        drive(100, 80, 1'b1, 1'b0, 1'b0);
        drive(64, 10, 1'b0, 1'b0, 1'b0);
        drive(1047, 80, 1'b1, 1'b0, 1'b0);
        drive(1048, 80, 1'b1, 1'b1, 1'b0);
        drive(1049, 80, 1'b1, 1'b0, 1'b0);
        flush();

        // Wrap-around and cancellation
        repeat (3) begin press(1); move_model(-1, 0); end
        check_cursor("left_to_0");
        press(1); move_model(-1, 0);
        check_cursor("left_wrap");
        repeat (2) begin press(3); move_model(0, -1); end
        press(3); move_model(0, -1);
        check_cursor("up_wrap");
        up = 1'b1; down = 1'b1; tick(); up = 1'b0; down = 1'b0; tick();
        check_cursor("up_down_cancel");
        left = 1'b1; right = 1'b1; tick(); left = 1'b0; right = 1'b0; tick();
        check_cursor("left_right_cancel");
        right = 1'b1; down = 1'b1; tick(); right = 1'b0; down = 1'b0; tick();
        move_model(1, 1);
        check_cursor("diag_wrap");

        // Paint with a simultaneous move lands on the pre-move cell
        paint_color = 12'h0A5;
        paint = 1'b1; right = 1'b1; tick(); paint = 1'b0; right = 1'b0; tick();
        mem_m[0] = 12'h0A5;
        move_model(1, 0);
        check_cursor("paint_move");

        // Held paint writes only once
        paint_color = 12'h123;
        paint = 1'b1;
        tick();
        paint_color = 12'h777;
        repeat (99) tick();
        paint = 1'b0;
        tick();
        mem_m[1] = 12'h123;
        drive(10, 10, 1'b0, 1'b0, 1'b0);
        drive(40, 10, 1'b0, 1'b0, 1'b0);
        drive(32, 10, 1'b0, 1'b0, 1'b0);
        drive(100, 80, 1'b0, 1'b0, 1'b0);
        flush();

        // Reset mid-operation, then again in the middle of the clear sweep
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (400) tick();
        n_assert++;
        assert (ready === 1'b0) else begin
            n_fail++;
            $error("FAIL ready_during_clear observed=%b expected=0", ready);
        end
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        ex_cx = 0;
        ex_cy = 0;
        clear_model();
        count_ready("restart_clear");
        check_cursor("cursor_after_reset");
        drive(100, 80, 1'b0, 1'b0, 1'b0);
        drive(10, 10, 1'b0, 1'b0, 1'b0);
        drive(40, 10, 1'b0, 1'b0, 1'b0);
        drive(0, 10, 1'b0, 1'b0, 1'b0);
        drive(64, 10, 1'b0, 1'b0, 1'b0);
        flush();

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
